n8_controller_reader: RTL and testbench
=======================================

# n8_controller_reader

Serial front end for the N8 (NES-style) game controller. The block drives the controller's latch and pulse lines and shifts in the 8 serial button bits. It synchronizes and decodes them, and presents them as registered, active-high, level `n8_*` button signals. Those signals are the ones `input_controller` consumes for movement and start edge detection. It sits between the GPIO pins and `input_controller`.

## Interface
- `CLK_DIV`, default 300: clk cycles per serial half-period (6 µs at 50 MHz). Must be ≥ 2.
- `POLL_PERIOD`, default 833_333: clk cycles between frame starts (60 Hz at 50 MHz). Must be > 17*CLK_DIV+1.
- `clk`  in  1  system clock; one clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `n8_data`  in  1  serial data from the controller, active-low (0 = pressed), asynchronous.
- `n8_latch`  out  1  latch strobe to the controller.
- `n8_pulse`  out  1  shift clock to the controller.
- `n8_a`, `n8_b`, `n8_select`, `n8_start`, `n8_up`, `n8_down`, `n8_left`, `n8_right`  out  1 each  decoded buttons, active-high, held between frames.
- `frame_valid`  out  1  one-cycle strobe; the button outputs updated on this cycle.

## Operation
- `n8_data` passes through a 2-flop synchronizer. All sampling uses the synchronized value.
- Poll counter:
  - Free-running, 0..POLL_PERIOD-1.
  - On wrap it raises a start request.
  - A request arriving while a frame is active is dropped; the frame is never restarted.
- Frame bit order (serial index 0..7): A, B, Select, Start, Up, Down, Left, Right.
- FSM states:
  - IDLE: latch=0, pulse=0. On start request → LATCH.
  - LATCH: latch=1 for 2*CLK_DIV cycles; bit index cleared to 0. Then → LOW.
  - LOW: pulse=0 for CLK_DIV cycles. On the last cycle, capture the synchronized bit at the current index. If the index is 7 → DONE, else → HIGH.
  - HIGH: pulse=1 for CLK_DIV cycles, then index+1 → LOW.
  - DONE: 1 cycle. Button outputs load the inverted shift register; frame_valid=1. Then → IDLE.
- Each frame produces exactly 7 pulses. Bit 0 is read after latch with no pulse.
- `n8_latch` and `n8_pulse` are registered FSM outputs (glitch-free).
- Button outputs change only in DONE. Activity on `n8_data` outside a frame has no effect.
- Reset, including mid-frame:
  - All outputs go to 0 on the next edge.
  - FSM → IDLE; poll, phase and index counters → 0; shift register → 0.
  - The next latch starts POLL_PERIOD cycles after reset release.

## Timing
- Reset values: n8_latch=0, n8_pulse=0, all `n8_*` buttons=0, frame_valid=0.
- First n8_latch rise occurs on the POLL_PERIOD-th rising edge after reset deasserts.
- Frame length from latch rise to frame_valid:
  - 2*CLK_DIV + 8*CLK_DIV (LOW) + 7*CLK_DIV (HIGH) = 17*CLK_DIV cycles.
  - frame_valid asserts in cycle 17*CLK_DIV after latch rise, for exactly 1 cycle.
- Successive latch rises are spaced exactly POLL_PERIOD cycles apart.
- Data setup: a bit is sampled 2*CLK_DIV cycles after the pulse edge that shifted it, which covers the 2-cycle synchronizer latency. This is why CLK_DIV ≥ 2.
- End-to-end latency from a button state to the `n8_*` outputs: at most POLL_PERIOD + 17*CLK_DIV cycles.

## Structure
- Package `n8_pkg`:
  - FSM state enum `n8_state_t` (IDLE, LATCH, LOW, HIGH, DONE).
  - Bit-index constants `N8_BIT_A` .. `N8_BIT_RIGHT`.
  - `N8_NUM_BITS` = 8.
- Sub-module `n8_sync`: parameterless 2-flop synchronizer, reused for other GPIO inputs.
- Everything else stays in one module: counters, FSM, shift register, output register.

## Test plan
Bench parameters: CLK_DIV=2, POLL_PERIOD=50. The behavioural controller model loads on latch and shifts on the pulse rising edge.
1. Reset held 5 cycles → latch, pulse, frame_valid and all buttons 0. First latch rise occurs 50 cycles after release.
2. Waveform check → latch high 4 cycles, then 7 pulses each high 2 / low 2. frame_valid is high exactly on cycle 34 after latch rise, for 1 cycle. The next latch rises 50 cycles after the previous one.
3. Model drives Start+Left pressed (`n8_data` low on bits 3 and 6) → at frame_valid n8_start=1 and n8_left=1; the other six buttons are 0.
4. All buttons pressed, then released in the next frame → all 8 outputs go 1 at the first frame_valid and all 0 at the second. Outputs hold their values between the two strobes.
5. `n8_data` toggled randomly only while IDLE → outputs unchanged, and no frame_valid outside DONE.
6. Reset asserted during the 4th pulse → latch/pulse/buttons 0 on the next edge and no frame_valid. The next latch occurs 50 cycles after release, and that frame decodes correctly.

Source files
------------

// File: rtl/n8_pkg.sv
// Shared types and constants for the N8 controller serial reader.
package n8_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LATCH = 3'd1,
        LOW   = 3'd2,
        HIGH  = 3'd3,
        DONE  = 3'd4
    } n8_state_t;

    localparam int N8_NUM_BITS  = 8;
    localparam int N8_BIT_A      = 0;
    localparam int N8_BIT_B      = 1;
    localparam int N8_BIT_SELECT = 2;
    localparam int N8_BIT_START  = 3;
    localparam int N8_BIT_UP     = 4;
    localparam int N8_BIT_DOWN   = 5;
    localparam int N8_BIT_LEFT   = 6;
    localparam int N8_BIT_RIGHT  = 7;

    // Field order puts A in bit 0 so the struct lines up with the serial index.
    typedef struct packed {
        logic right;
        logic left;
        logic down;
        logic up;
        logic start;
        logic select_b;
        logic b;
        logic a;
    } n8_buttons_t;

    // Serial data is active-low; a pressed button reads back as 0.
    function automatic n8_buttons_t n8_decode(input logic [N8_NUM_BITS-1:0] raw);
        return n8_buttons_t'(~raw);
    endfunction

endpackage

// File: rtl/n8_controller_reader_if.sv
// Pad-side and decoded-button signals of the N8 controller reader.
interface n8_controller_reader_if;
    logic n8_data;
    logic n8_latch;
    logic n8_pulse;
    logic n8_a;
    logic n8_b;
    logic n8_select;
    logic n8_start;
    logic n8_up;
    logic n8_down;
    logic n8_left;
    logic n8_right;
    logic frame_valid;

    modport master (
        input  n8_data,
        output n8_latch, n8_pulse,
        output n8_a, n8_b, n8_select, n8_start,
        output n8_up, n8_down, n8_left, n8_right,
        output frame_valid
    );

    modport slave (
        output n8_data,
        input  n8_latch, n8_pulse,
        input  n8_a, n8_b, n8_select, n8_start,
        input  n8_up, n8_down, n8_left, n8_right,
        input  frame_valid
    );
endinterface

// File: rtl/n8_sync.sv
// Two-flop synchronizer for a single asynchronous GPIO input.
module n8_sync (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic meta_r;
    logic sync_r;

    // Two back-to-back flops give the first one a full cycle to resolve.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;
endmodule

// File: rtl/n8_controller_reader.sv
// Polls an N8 controller: drives latch/pulse, shifts in 8 bits, presents
// registered active-high button levels with a one-cycle frame_valid strobe.
module n8_controller_reader
    import n8_pkg::*;
#(
    parameter int CLK_DIV     = 300,
    parameter int POLL_PERIOD = 833_333
) (
    input  logic                   clk,
    input  logic                   reset,
    n8_controller_reader_if.master bus
);
    localparam int POLL_W = $clog2(POLL_PERIOD);
    localparam int PH_W   = $clog2(2 * CLK_DIV);
    localparam int IDX_W  = $clog2(N8_NUM_BITS);

    localparam logic [POLL_W-1:0] POLL_LAST  = POLL_W'(POLL_PERIOD - 1);
    localparam logic [PH_W-1:0]   LATCH_LAST = PH_W'(2 * CLK_DIV - 1);
    localparam logic [PH_W-1:0]   HALF_LAST  = PH_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(N8_NUM_BITS - 1);

    logic                   data_sync_s;
    logic                   start_req_s;
    logic [POLL_W-1:0]      poll_cnt_r;
    n8_state_t              state_r, state_nx_s;
    logic [PH_W-1:0]        phase_r, phase_nx_s;
    logic [IDX_W-1:0]       idx_r, idx_nx_s;
    logic [N8_NUM_BITS-1:0] shift_r, shift_nx_s;
    logic                   latch_r;
    logic                   pulse_r;
    logic                   frame_valid_r;
    n8_buttons_t            buttons_r;

    n8_sync u_data_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.n8_data),
        .q     (data_sync_s)
    );

    assign start_req_s = (poll_cnt_r == POLL_LAST);

    // Free-running frame-rate counter; a wrap that lands mid-frame is ignored by the FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            poll_cnt_r <= '0;
        end else if (start_req_s) begin
            poll_cnt_r <= '0;
        end else begin
            poll_cnt_r <= poll_cnt_r + POLL_W'(1);
        end
    end

    // Next-state, phase/index sequencing and bit capture.
    always_comb begin
        state_nx_s = state_r;
        phase_nx_s = phase_r + PH_W'(1);
        idx_nx_s   = idx_r;
        shift_nx_s = shift_r;
        case (state_r)
            IDLE: begin
                phase_nx_s = '0;
                idx_nx_s   = '0;
                if (start_req_s) begin
                    state_nx_s = LATCH;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            LATCH: begin
                idx_nx_s = '0;
                if (phase_r == LATCH_LAST) begin
                    state_nx_s = LOW;
                    phase_nx_s = '0;
                end else begin
                    state_nx_s = LATCH;
                end
            end
            LOW: begin
                // Sampling at the end of the low half leaves 2*CLK_DIV cycles after the shifting edge.
                if (phase_r == HALF_LAST) begin
                    shift_nx_s[idx_r] = data_sync_s;
                    phase_nx_s        = '0;
                    if (idx_r == IDX_LAST) begin
                        state_nx_s = DONE;
                    end else begin
                        state_nx_s = HIGH;
                    end
                end else begin
                    state_nx_s = LOW;
                end
            end
            HIGH: begin
                if (phase_r == HALF_LAST) begin
                    state_nx_s = LOW;
                    phase_nx_s = '0;
                    idx_nx_s   = idx_r + IDX_W'(1);
                end else begin
                    state_nx_s = HIGH;
                end
            end
            DONE: begin
                state_nx_s = IDLE;
                phase_nx_s = '0;
            end
            default: begin
                state_nx_s = IDLE;
                phase_nx_s = '0;
                idx_nx_s   = '0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            phase_r <= '0;
            idx_r   <= '0;
            shift_r <= '0;
        end else begin
            state_r <= state_nx_s;
            phase_r <= phase_nx_s;
            idx_r   <= idx_nx_s;
            shift_r <= shift_nx_s;
        end
    end

    // Outputs are registered from the next state so they align with it and never glitch.
    always_ff @(posedge clk) begin
        if (reset) begin
            latch_r       <= 1'b0;
            pulse_r       <= 1'b0;
            frame_valid_r <= 1'b0;
            buttons_r     <= n8_buttons_t'(8'h00);
        end else begin
            latch_r       <= (state_nx_s == LATCH);
            pulse_r       <= (state_nx_s == HIGH);
            frame_valid_r <= (state_nx_s == DONE);
            if (state_nx_s == DONE) begin
                buttons_r <= n8_decode(shift_nx_s);
            end else begin
                buttons_r <= buttons_r;
            end
        end
    end

    assign bus.n8_latch    = latch_r;
    assign bus.n8_pulse    = pulse_r;
    assign bus.frame_valid = frame_valid_r;
    assign bus.n8_a        = buttons_r.a;
    assign bus.n8_b        = buttons_r.b;
    assign bus.n8_select   = buttons_r.select_b;
    assign bus.n8_start    = buttons_r.start;
    assign bus.n8_up       = buttons_r.up;
    assign bus.n8_down     = buttons_r.down;
    assign bus.n8_left     = buttons_r.left;
    assign bus.n8_right    = buttons_r.right;
endmodule

// File: tb/tb_n8_controller_reader.sv
// Scoreboard bench: a behavioural NES-style pad model feeds the reader; a monitor
// checks waveform timing against the frame schedule and buttons against queued pad states.
module tb_n8_controller_reader;
    localparam int CLK_DIV = 2;
    localparam int POLL    = 50;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    n8_controller_reader_if bus ();

    n8_controller_reader #(
        .CLK_DIV     (CLK_DIV),
        .POLL_PERIOD (POLL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          n_pass   = 0;
    int          n_total  = 0;
    int          exp_t    = 0;
    logic [7:0]  pad      = 8'h00;
    logic        noise_en = 1'b0;
    logic [7:0]  exp_btn  = 8'h00;
    logic [7:0]  exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, req, $time);
        end
    endtask

    function automatic logic [7:0] dut_btn();
        return {bus.n8_right, bus.n8_left, bus.n8_down, bus.n8_up,
                bus.n8_start, bus.n8_select, bus.n8_b, bus.n8_a};
    endfunction

    // Expected {latch, pulse, frame_valid} t cycles after reset release.
    function automatic logic [2:0] exp_wave(input int t);
        int   ph;
        logic l, p, f;
        if (t < POLL) return 3'b000;
        ph = t % POLL;
        l  = (ph < 2*CLK_DIV);
        p  = (ph >= 2*CLK_DIV) && (ph < 16*CLK_DIV) && (((ph - 2*CLK_DIV) % (2*CLK_DIV)) >= CLK_DIV);
        f  = (ph == 17*CLK_DIV);
        return {l, p, f};
    endfunction

    // Controller model: parallel load while latched, shift on pulse rise, data active-low.
    initial begin
        logic [7:0] sh = 8'h00;
        logic       pl = 1'b0;
        logic       pp = 1'b0;
        bus.n8_data = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.n8_latch) begin
                sh = pad;
                if (!pl) exp_q.push_back(pad);
            end else if (bus.n8_pulse && !pp) begin
                sh = {1'b0, sh[7:1]};
            end
            pl = bus.n8_latch;
            pp = bus.n8_pulse;
            bus.n8_data = noise_en ? 1'($urandom) : ~sh[0];
        end
    end

    // Monitor: timing schedule, scoreboard pop on frame_valid, held button levels.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_t   = 0;
                exp_btn = 8'h00;
                chk("reset_outputs", {bus.n8_latch, bus.n8_pulse, bus.frame_valid, dut_btn()}, 32'd0);
            end else begin
                exp_t++;
                chk("waveform", {bus.n8_latch, bus.n8_pulse, bus.frame_valid}, exp_wave(exp_t));
                if (bus.frame_valid) begin
                    chk("sb_entry_present", (exp_q.size() > 0), 1'b1);
                    if (exp_q.size() > 0) exp_btn = exp_q.pop_front();
                end
                chk("buttons", dut_btn(), exp_btn);
            end
        end
    end

    task automatic wait_fv();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.frame_valid && n < 200);
        chk("frame_valid_timeout", (n < 200), 1'b1);
        #1;
    endtask

    initial begin
        int n;
        pad   = 8'b0100_1000;
        reset = 1'b1;
        repeat (5) @(negedge clk);
        #1 reset = 1'b0;
        wait_fv();
        pad = 8'hFF;
        wait_fv();
        pad = 8'h00;
        wait_fv();
        for (int i = 0; i < 4; i++) begin
            pad      = 8'($urandom);
            noise_en = 1'b1;
            repeat (10) @(negedge clk);
            #1 noise_en = 1'b0;
            wait_fv();
        end
        // Assert reset at the start of the 4th pulse's high half.
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!(exp_t >= POLL && (exp_t % POLL) == 6*CLK_DIV + 3*CLK_DIV) && n < 200);
        chk("pulse4_found", (n < 200), 1'b1);
        chk("pulse4_high", bus.n8_pulse, 1'b1);
        reset = 1'b1;
        exp_q.delete();
        pad = 8'($urandom);
        repeat (3) @(negedge clk);
        #1 reset = 1'b0;
        wait_fv();
        repeat (20) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
